// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: bundles the instruction-memory port and the decode-side signals of the
// fetch stage.
//   master : the fetch_buffer side (drives imem_en/imem_addr and the *_d outputs)
//   slave  : the environment side (memory model, decode, execute redirect)
// Optional FETCH_MISALIGN_TRAP_EN adds fetch_misalign_d / misalign_addr_d.
interface fetch_buffer_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign_d;
    logic [31:0] misalign_addr_d;
`endif

    modport master (
        input  imem_rdata, stall_d, pc_src_e, pc_target_e,
`ifdef FETCH_MISALIGN_TRAP_EN
        output fetch_misalign_d, misalign_addr_d,
`endif
        output imem_en, imem_addr, valid_d, instr_d, pc_d, pcplus4_d
    );

    modport slave (
        output imem_rdata, stall_d, pc_src_e, pc_target_e,
`ifdef FETCH_MISALIGN_TRAP_EN
        input  fetch_misalign_d, misalign_addr_d,
`endif
        input  imem_en, imem_addr, valid_d, instr_d, pc_d, pcplus4_d
    );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch stage. Owns the fetch PC, issues reads to a 1-cycle
// instruction memory and buffers returned words in a DEPTH-entry FIFO feeding decode.
// A redirect from execute flushes the FIFO and squashes the outstanding read.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : fetch_buffer_if.master (imem request/response, decode outputs, redirect)
// Parameters: RESET_PC (fetch address after reset), DEPTH (FIFO entries, power of two >= 2).
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target halts fetch and raises
// fetch_misalign_d until the next redirect; without it, target bits [1:0] are forced to 00.
module fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic           clk,
    input  logic           reset,
    fetch_buffer_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [31:0]      fifo_instr [DEPTH];
    logic [31:0]      fifo_pc    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             inflight;
    logic [31:0]      inflight_addr;
    logic [31:0]      pc_f;
    logic [0:0]       state;
    logic [31:0]      target;

    logic             valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occ_next;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic             misalign;
    logic [31:0]      misalign_addr;

    assign target = bus.pc_target_e;
    assign bus.fetch_misalign_d = misalign;
    assign bus.misalign_addr_d  = misalign_addr;
`else
    assign target = bus.pc_target_e & ~32'h3;
`endif

    always_comb begin
        valid    = ~reset & (count != '0);
        pop      = valid & ~bus.stall_d;
        // A redirect this cycle squashes the returning read.
        push     = inflight & ~bus.pc_src_e;
        // Occupancy once the current response lands and the head leaves; a new read is only
        // issued if it is guaranteed a free slot when its data returns.
        occ_next = {1'b0, count} - {{CNT_W{1'b0}}, pop} + {{CNT_W{1'b0}}, inflight};
        issue    = ~reset & ~bus.pc_src_e & (state == ST_RUN)
                 & (occ_next < (CNT_W + 1)'(DEPTH));
    end

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_f;
    assign bus.valid_d   = valid;
    assign bus.instr_d   = valid ? fifo_instr[rd_ptr] : 32'h0000_0013;
    assign bus.pc_d      = valid ? fifo_pc[rd_ptr] : 32'h0;
    assign bus.pcplus4_d = valid ? fifo_pc[rd_ptr] + 32'd4 : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            inflight      <= 1'b0;
            inflight_addr <= 32'h0;
            pc_f          <= RESET_PC;
            state         <= ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign      <= 1'b0;
            misalign_addr <= 32'h0;
`endif
        end else if (bus.pc_src_e) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            pc_f     <= target;
`ifdef FETCH_MISALIGN_TRAP_EN
            // Any redirect while halted is the trap vector and resumes fetching.
            if (state == ST_HALT) begin
                state    <= ST_RUN;
                misalign <= 1'b0;
            end else if (target[1:0] != 2'b00) begin
                state         <= ST_HALT;
                misalign      <= 1'b1;
                misalign_addr <= target;
            end
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            inflight <= issue;
            if (issue) begin
                inflight_addr <= pc_f;
                pc_f          <= pc_f + 32'd4;
            end
        end
    end

    // Storage is not reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= inflight_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && count == CNT_W'(DEPTH)))
            else $error("fetch_buffer: push into full FIFO");
        end
    end
endmodule
